rr_out_port: RTL

RR_OUT_PORT -- requirements
Module: rr_out_port

---
 rtl/rr_out_port_pkg.sv | 21 ++
 rtl/rr_out_port_pkt.sv | 3 +
 rtl/rr_out_port_fifo.sv | 57 +++++
 rtl/rr_out_port.sv | 113 +++++++++++
 4 files changed

// File: rtl/rr_out_port_pkg.sv
// Shared NoC definitions: packet type, packet byte count and serializer states.
package rr_out_port_pkg;

  localparam int PKT_BYTES = 4;
  localparam int PKT_W     = 8 * PKT_BYTES;

  typedef struct packed {
    logic [7:0]  dest_id;
    logic [23:0] body;
  } pkt_t;

  typedef enum logic {IDLE, SEND} ser_state_t;

  // idx counts byte lanes from the least significant end of the packet.
  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    logic [PKT_W-1:0] raw;
    raw = p;
    return raw[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rr_out_port_pkt.sv
// Empty auxiliary package; packet definitions live in rr_out_port_pkg.
package rr_out_port_unused_pkg;
endpackage

// File: rtl/rr_out_port_fifo.sv
// Packet FIFO: DEPTH entries, power-of-two depth so pointers wrap naturally.
module pkt_fifo
  import rr_out_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       wr_en,
  input  pkt_t                       wr_data,
  input  logic                       rd_en,
  output pkt_t                       rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rr_out_port.sv
// Output port: arbitrates input channels into a packet FIFO and serializes
// each packet MSB byte first to the downstream node.
module rr_out_port
  import rr_out_port_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  pkt_t [NUM_IN-1:0]          pkts_in,
  input  logic [NUM_IN-1:0]          pkts_avail,
  output logic [NUM_IN-1:0]          pkt_accept,
  input  logic                       free,
  output logic                       put,
  output logic [7:0]                 payload_out,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int LGW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [LGW-1:0] last_grant_q, last_grant_d, win_idx;
  ser_state_t     state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  pkt_t           shift_q, shift_d;
  pkt_t           head;
  logic           empty, pop, push;
  int             cand;

  // Candidates are visited lowest priority first so the last hit wins.
  always_comb begin
    pkt_accept = '0;
    win_idx    = '0;
    cand       = 0;
    if (rst_b && !full) begin
      for (int i = NUM_IN; i >= 1; i--) begin
        if (ARB_MODE == 1) begin
          cand = i - 1;
        end else begin
          cand = int'(last_grant_q) + i;
          if (cand >= NUM_IN) cand = cand - NUM_IN;
        end
        if (pkts_avail[cand[LGW-1:0]]) begin
          pkt_accept                 = '0;
          pkt_accept[cand[LGW-1:0]]  = 1'b1;
          win_idx                    = cand[LGW-1:0];
        end
      end
    end
  end

  assign push         = |pkt_accept;
  assign last_grant_d = push ? win_idx : last_grant_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) last_grant_q <= LGW'(NUM_IN - 1);
    else        last_grant_q <= last_grant_d;
  end

  pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (push),
    .wr_data (pkts_in[win_idx]),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign pop = (state_q == IDLE) && !empty && free;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = SEND;
          byte_cnt_d = 2'd0;
          shift_d    = head;
        end
      end
      SEND: begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'(PKT_BYTES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign put         = (state_q == SEND);
  assign payload_out = put ? pkt_byte(shift_q, 2'(PKT_BYTES - 1) - byte_cnt_q) : 8'h00;

endmodule
